// File: rtl/hex_7seg_scan.sv
// rtl/hex_7seg_scan.sv - multiplexed hex 7-segment scanner with shadowed digits, optional LEADING_ZERO_BLANK_EN
module hex_7seg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    scan_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic [3:0]            nibble;
    logic                  cur_dp;
    logic                  cur_en;
    logic                  blank;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    function automatic logic [6:0] hex_pattern(input logic [3:0] n);
        case (n)
            4'h0: hex_pattern = 7'h3F;
            4'h1: hex_pattern = 7'h06;
            4'h2: hex_pattern = 7'h5B;
            4'h3: hex_pattern = 7'h4F;
            4'h4: hex_pattern = 7'h66;
            4'h5: hex_pattern = 7'h6D;
            4'h6: hex_pattern = 7'h7D;
            4'h7: hex_pattern = 7'h07;
            4'h8: hex_pattern = 7'h7F;
            4'h9: hex_pattern = 7'h67;
            4'hA: hex_pattern = 7'h77;
            4'hB: hex_pattern = 7'h7C;
            4'hC: hex_pattern = 7'h39;
            4'hD: hex_pattern = 7'h5E;
            4'hE: hex_pattern = 7'h79;
            default: hex_pattern = 7'h71;
        endcase
    endfunction

    always_comb begin
        nibble = 4'h0;
        cur_dp = 1'b0;
        cur_en = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nibble = shadow_value[i*4 +: 4];
                cur_dp = shadow_dp[i];
                cur_en = digit_en[i];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IW-1:0] top_idx;

    // Highest nonzero nibble; all-zero value leaves digit 0 as the top, so it stays lit.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shadow_value[i*4 +: 4] != 4'h0) top_idx = IW'(i);
        end
    end

    assign blank = (idx > top_idx);
`else
    assign blank = 1'b0;
`endif

    assign lit = cur_en && !blank;

    always_comb begin
        an_next  = '1;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (lit) begin
            seg_next = ~hex_pattern(nibble);
            dp_next  = ~cur_dp;
            // First clock of each slot keeps all anodes off to avoid ghosting.
            if (cnt != '0) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx == IW'(i)) an_next[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            seg          <= 7'h7F;
            dp           <= 1'b1;
            an           <= '1;
            scan_tick    <= 1'b0;
        end else begin
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp_in;
            end
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            seg       <= seg_next;
            dp        <= dp_next;
            an        <= an_next;
            scan_tick <= (cnt == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_hex_7seg_scan.sv
// tb/tb_hex_7seg_scan.sv - directed-vector bench for hex_7seg_scan (4 digits, SCAN_DIV 4)
module tb_hex_7seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        scan_tick;

    int n_cmp = 0;
    int n_bad = 0;

    hex_7seg_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .scan_tick (scan_tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Period starting at pre-state cnt=1, idx=1 with shadow 12AF, dp_in 0.
    logic [3:0] per_an   [16] = '{4'hD, 4'hD, 4'hD, 4'hF, 4'hB, 4'hB, 4'hB, 4'hF,
                                  4'h7, 4'h7, 4'h7, 4'hF, 4'hE, 4'hE, 4'hE, 4'hF};
    logic [6:0] per_seg  [16] = '{7'h08, 7'h08, 7'h08, 7'h00, 7'h24, 7'h24, 7'h24, 7'h00,
                                  7'h79, 7'h79, 7'h79, 7'h00, 7'h0E, 7'h0E, 7'h0E, 7'h00};
    logic       per_tick [16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset    = 1'b1;
        load     = 1'b1;
        value    = 16'h12AF;
        dp_in    = 4'h0;
        digit_en = 4'hF;
        step();
        step();
        check_val("rst_an", 32'(an), 32'hF);
        check_val("rst_seg", 32'(seg), 32'h7F);
        check_val("rst_dp", 32'(dp), 32'h1);
        check_val("rst_tick", 32'(scan_tick), 32'h0);

        reset = 1'b0;
        load  = 1'b0;
        step();
        check_val("guard_an", 32'(an), 32'hF);
        step();
        check_val("first_an", 32'(an), 32'hE);
        check_val("rst_over_load_seg", 32'(seg), 32'h40);

        load  = 1'b1;
        value = 16'h0008;
        step();
        load = 1'b0;
        check_val("midload_seg_old", 32'(seg), 32'h40);
        check_val("midload_an_old", 32'(an), 32'hE);
        step();
        check_val("midload_seg_new", 32'(seg), 32'h00);
        check_val("midload_an_new", 32'(an), 32'hE);
        check_val("midload_tick", 32'(scan_tick), 32'h1);

        load  = 1'b1;
        value = 16'h12AF;
        step();
        load = 1'b0;
        check_val("slot_guard_an", 32'(an), 32'hF);
        check_val("slot_guard_tick", 32'(scan_tick), 32'h0);

        for (int pass = 0; pass < 2; pass++) begin
            digit_en = (pass == 0) ? 4'hF : 4'hB;
            for (int k = 0; k < 16; k++) begin
                step();
                if (pass == 1 && k >= 4 && k <= 6) begin
                    check_val($sformatf("mask_an_%0d", k), 32'(an), 32'hF);
                    check_val($sformatf("mask_seg_%0d", k), 32'(seg), 32'h7F);
                    check_val($sformatf("mask_dp_%0d", k), 32'(dp), 32'h1);
                end else begin
                    check_val($sformatf("scan%0d_an_%0d", pass, k), 32'(an), 32'(per_an[k]));
                    if (per_an[k] != 4'hF) begin
                        check_val($sformatf("scan%0d_seg_%0d", pass, k), 32'(seg), 32'(per_seg[k]));
                        check_val($sformatf("scan%0d_dp_%0d", pass, k), 32'(dp), 32'h1);
                    end
                end
                check_val($sformatf("scan%0d_tick_%0d", pass, k), 32'(scan_tick), 32'(per_tick[k]));
            end
        end

        digit_en = 4'hF;
        load     = 1'b1;
        value    = 16'h0050;
        dp_in    = 4'b0010;
        step();
        load = 1'b0;
        for (int j = 0; j < 16; j++) begin
            step();
            if (j == 0) begin
                check_val("lz_d1_an", 32'(an), 32'hD);
                check_val("lz_d1_seg", 32'(seg), 32'h12);
                check_val("lz_d1_dp", 32'(dp), 32'h0);
            end
            if (j == 4) begin
`ifdef LEADING_ZERO_BLANK_EN
                check_val("lz_d2_an", 32'(an), 32'hF);
                check_val("lz_d2_seg", 32'(seg), 32'h7F);
`else
                check_val("lz_d2_an", 32'(an), 32'hB);
                check_val("lz_d2_seg", 32'(seg), 32'h40);
`endif
                check_val("lz_d2_dp", 32'(dp), 32'h1);
            end
            if (j == 8) begin
`ifdef LEADING_ZERO_BLANK_EN
                check_val("lz_d3_an", 32'(an), 32'hF);
                check_val("lz_d3_seg", 32'(seg), 32'h7F);
`else
                check_val("lz_d3_an", 32'(an), 32'h7);
                check_val("lz_d3_seg", 32'(seg), 32'h40);
`endif
            end
            if (j == 12) begin
                check_val("lz_d0_an", 32'(an), 32'hE);
                check_val("lz_d0_seg", 32'(seg), 32'h40);
                check_val("lz_d0_dp", 32'(dp), 32'h1);
            end
        end

        reset = 1'b1;
        step();
        step();
        check_val("midrst_an", 32'(an), 32'hF);
        check_val("midrst_seg", 32'(seg), 32'h7F);
        check_val("midrst_dp", 32'(dp), 32'h1);
        check_val("midrst_tick", 32'(scan_tick), 32'h0);
        reset = 1'b0;
        step();
        check_val("midrst_guard_an", 32'(an), 32'hF);
        step();
        check_val("midrst_idx0_an", 32'(an), 32'hE);
        check_val("midrst_idx0_seg", 32'(seg), 32'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
